// File: rtl/fc_pkg.sv
// Shared types and helpers for the sequential fully-connected layer engine.
package fc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StFinish,
        StDone
    } fc_state_e;

    function automatic int unsigned fc_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

    // Optional ReLU then saturation to a signed dw-bit range; caller truncates to dw bits.
    function automatic logic signed [63:0] fc_sat_relu(input logic signed [63:0] s,
                                                       input int unsigned      dw,
                                                       input bit               relu);
        logic signed [63:0] hi, lo, r;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        r  = s;
        if (relu && (r < 0)) r = '0;
        if (r > hi)      r = hi;
        else if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output neuron: signed MAC accumulator plus the bias / rescale / ReLU / saturate stage.
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned FRAC_BITS  = 0,
    parameter int unsigned RELU_EN    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic                         fin,
    input  logic signed [DATA_WIDTH-1:0] act,
    input  logic signed [DATA_WIDTH-1:0] weight,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic        [DATA_WIDTH-1:0] result
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic signed [63:0]             sum;
    logic        [DATA_WIDTH-1:0]   result_q, result_d;

    always_comb begin
        prod  = act * weight;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_WIDTH'(prod);
        end
        // Bias is aligned to the accumulator's fixed point before the arithmetic rescale.
        sum      = (64'(acc_q) + (64'(bias) <<< FRAC_BITS)) >>> FRAC_BITS;
        result_d = DATA_WIDTH'(fc_sat_relu(sum, DATA_WIDTH, RELU_EN != 0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (fin) result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/fc_layer_seq.sv
// Sequential FC layer: streams activations one per cycle into parallel MAC lanes fed by an
// external synchronous weight memory, with a start/busy/done handshake.
module fc_layer_seq
    import fc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned INPUT_NODES  = 128,
    parameter int unsigned OUTPUT_NODES = 16,
    parameter int unsigned ACC_WIDTH    = 24,
    parameter int unsigned FRAC_BITS    = 0,
    parameter int unsigned RELU_EN      = 1,
    parameter int unsigned ADDR_WIDTH   = (INPUT_NODES > 1) ? fc_clog2(INPUT_NODES) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [DATA_WIDTH*INPUT_NODES-1:0]  input_fc,
    input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] bias,
    output logic                               weight_rd,
    output logic [ADDR_WIDTH-1:0]              weight_addr,
    input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] weight_data,
    output logic                               busy,
    output logic                               done,
    output logic [DATA_WIDTH*OUTPUT_NODES-1:0] output_fc
);

    localparam int unsigned MinAcc = 2 * DATA_WIDTH + fc_clog2(INPUT_NODES);

    if (ACC_WIDTH < MinAcc) begin : g_acc_check
        $error("fc_layer_seq: ACC_WIDTH too small, accumulator may wrap");
    end

    fc_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] act_idx_q;
    logic                  mac_en_q;
    logic                  clr, fin, accept;
    logic [DATA_WIDTH-1:0] act_q [INPUT_NODES];

    assign accept = (state_q == StIdle) && start;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr     = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    idx_d   = '0;
                    clr     = 1'b1;
                end
            end
            StFetch: begin
                if (idx_q == ADDR_WIDTH'(INPUT_NODES - 1)) state_d = StDrain;
                else                                       idx_d   = idx_q + 1'b1;
            end
            StDrain:  state_d = StFinish;
            StFinish: begin
                fin     = 1'b1;
                state_d = StDone;
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            act_idx_q <= '0;
            mac_en_q  <= 1'b0;
            for (int j = 0; j < int'(INPUT_NODES); j++) act_q[j] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            // Weight row arrives one cycle after its address; delay index and enable to match.
            act_idx_q <= idx_q;
            mac_en_q  <= (state_q == StFetch);
            if (accept) begin
                for (int j = 0; j < int'(INPUT_NODES); j++) begin
                    act_q[j] <= input_fc[DATA_WIDTH*j +: DATA_WIDTH];
                end
            end
        end
    end

    assign weight_rd   = (state_q == StFetch);
    assign weight_addr = idx_q;
    assign busy        = (state_q == StFetch) || (state_q == StDrain) || (state_q == StFinish);
    assign done        = (state_q == StDone);

    for (genvar i = 0; i < int'(OUTPUT_NODES); i++) begin : g_lane
        fc_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .RELU_EN    (RELU_EN)
        ) u_lane (
            .clk    (clk),
            .rst_n  (reset),
            .clr    (clr),
            .en     (mac_en_q),
            .fin    (fin),
            .act    (act_q[act_idx_q]),
            .weight (weight_data[DATA_WIDTH*i +: DATA_WIDTH]),
            .bias   (bias[DATA_WIDTH*i +: DATA_WIDTH]),
            .result (output_fc[DATA_WIDTH*i +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench: three 4-input / 2-lane instances (ReLU, linear, FRAC_BITS=4), each with a
// synchronous weight-memory model.
module tb_fc_layer_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, start_c;
    logic [31:0] in_fc;
    logic [15:0] bias_v;

    logic        rd_a, rd_b, rd_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [1:0]  addr_a, addr_b, addr_c;
    logic [15:0] wd_a = '0, wd_b = '0, wd_c = '0;
    logic [15:0] out_a, out_b, out_c;
    logic [15:0] mem_a [4];
    logic [15:0] mem_b [4];
    logic [15:0] mem_c [4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_a) wd_a <= mem_a[addr_a];
        if (rd_b) wd_b <= mem_b[addr_b];
        if (rd_c) wd_c <= mem_c[addr_c];
    end

    fc_layer_seq #(
        .DATA_WIDTH(8), .INPUT_NODES(4), .OUTPUT_NODES(2), .ACC_WIDTH(24),
        .FRAC_BITS(0), .RELU_EN(1)
    ) u_dut_a (
        .clk(clk), .reset(rst_n), .start(start_a), .input_fc(in_fc), .bias(bias_v),
        .weight_rd(rd_a), .weight_addr(addr_a), .weight_data(wd_a),
        .busy(busy_a), .done(done_a), .output_fc(out_a)
    );

    fc_layer_seq #(
        .DATA_WIDTH(8), .INPUT_NODES(4), .OUTPUT_NODES(2), .ACC_WIDTH(24),
        .FRAC_BITS(0), .RELU_EN(0)
    ) u_dut_b (
        .clk(clk), .reset(rst_n), .start(start_b), .input_fc(in_fc), .bias(bias_v),
        .weight_rd(rd_b), .weight_addr(addr_b), .weight_data(wd_b),
        .busy(busy_b), .done(done_b), .output_fc(out_b)
    );

    fc_layer_seq #(
        .DATA_WIDTH(8), .INPUT_NODES(4), .OUTPUT_NODES(2), .ACC_WIDTH(24),
        .FRAC_BITS(4), .RELU_EN(1)
    ) u_dut_c (
        .clk(clk), .reset(rst_n), .start(start_c), .input_fc(in_fc), .bias(bias_v),
        .weight_rd(rd_c), .weight_addr(addr_c), .weight_data(wd_c),
        .busy(busy_c), .done(done_c), .output_fc(out_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Rows are {lane1, lane0}.
    task automatic set_mem(input int inst, input logic [15:0] r0, input logic [15:0] r1,
                           input logic [15:0] r2, input logic [15:0] r3);
        logic [15:0] rows [4];
        rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
        for (int j = 0; j < 4; j++) begin
            if (inst == 0)      mem_a[j] = rows[j];
            else if (inst == 1) mem_b[j] = rows[j];
            else                mem_c[j] = rows[j];
        end
    endtask

    // Cycle-accurate run on instance A. k counts negedges after the start cycle T.
    task automatic run_a(input logic [31:0] inp, input logic [15:0] b, input logic [15:0] exp,
                         input bit poke, input int abort_k);
        in_fc  = inp;
        bias_v = b;
        @(negedge clk);
        start_a = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start_a = poke && (k == 2 || k == 7);
            if (poke && k == 1) in_fc = 32'h7f7f_7f7f;
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                check_eq("abort_busy", busy_a, 0);
                check_eq("abort_done", done_a, 0);
                check_eq("abort_rd",   rd_a,   0);
                check_eq("abort_addr", addr_a, 0);
                check_eq("abort_out",  out_a,  0);
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            check_eq("busy", busy_a, (k <= 6));
            check_eq("done", done_a, (k == 7));
            check_eq("wrd",  rd_a,   (k <= 4));
            if (k <= 4) check_eq("waddr", addr_a, k - 1);
            if (k >= 7) check_eq("out_a", out_a, exp);
        end
        if (poke) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                check_eq("idle_busy", busy_a, 0);
                check_eq("idle_done", done_a, 0);
            end
            check_eq("out_hold", out_a, exp);
        end
    endtask

    // Latency and result check on instance B (inst=1) or C (inst=2).
    task automatic run_other(input int inst, input logic [31:0] inp, input logic [15:0] b,
                             input logic [15:0] exp);
        bit found;
        found  = 1'b0;
        in_fc  = inp;
        bias_v = b;
        @(negedge clk);
        if (inst == 1) start_b = 1'b1;
        else           start_c = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start_b = 1'b0;
            start_c = 1'b0;
            if ((inst == 1) ? done_b : done_c) begin
                found = 1'b1;
                check_eq("latency", k, 7);
                check_eq((inst == 1) ? "out_b" : "out_c", (inst == 1) ? out_b : out_c, exp);
                break;
            end
        end
        check_eq("done_seen", found, 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        in_fc   = '0;
        bias_v  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_rd",   rd_a,   0);
        check_eq("rst_addr", addr_a, 0);
        check_eq("rst_out",  out_a,  0);
        check_eq("rst_out_b", out_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Inputs 1..4, lane0 w=1, lane1 w=-1: lane0=10, lane1=-10 -> ReLU 0.
        set_mem(0, 16'hff01, 16'hff01, 16'hff01, 16'hff01);
        run_a(32'h0403_0201, 16'h0000, 16'h000a, 1'b0, 0);

        // Per-row weights, biases {-3,5}: lane0=30+5=35, lane1=4-3=1; pokes and input change ignored.
        set_mem(0, 16'h0201, 16'hff02, 16'h0003, 16'h0104);
        run_a(32'h0403_0201, 16'hfd05, 16'h0123, 1'b1, 0);

        // Reset at T+3 aborts, then a fresh run gives the standard result and latency.
        set_mem(0, 16'hff01, 16'hff01, 16'hff01, 16'hff01);
        run_a(32'h0403_0201, 16'h0000, 16'h000a, 1'b0, 3);
        run_a(32'h0403_0201, 16'h0000, 16'h000a, 1'b0, 0);

        // Linear instance: -10 passes through; then saturation both ways.
        set_mem(1, 16'hff01, 16'hff01, 16'hff01, 16'hff01);
        run_other(1, 32'h0403_0201, 16'h0000, 16'hf60a);
        set_mem(1, 16'h807f, 16'h807f, 16'h807f, 16'h807f);
        run_other(1, 32'h7f7f_7f7f, 16'h0000, 16'h807f);

        // FRAC_BITS=4: (512+16)>>4=33, (512-16)>>4=31.
        set_mem(2, 16'h0808, 16'h0808, 16'h0808, 16'h0808);
        run_other(2, 32'h1010_1010, 16'hff01, 16'h1f21);
        // Truncating rescale: lane0 50>>4=3, lane1 (30+16)>>4=2.
        set_mem(2, 16'h0305, 16'h0305, 16'h0305, 16'h0305);
        run_other(2, 32'h0403_0201, 16'h0100, 16'h0203);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
Sequential fully-connected layer engine, successor to the broadcast-input FC layer. It streams INPUT_NODES activations one per cycle into OUTPUT_NODES parallel MAC lanes. Each lane reads its weight column from an external synchronous weight memory, then applies bias, fixed-point rescale, optional ReLU and saturation. A start/busy/done handshake replaces the free-running input index, so layers can be chained by a network-level sequencer.

Parameters:
DATA_WIDTH, 8, signed width of activations, weights, biases and outputs
INPUT_NODES, 128, number of input activations (>=1)
OUTPUT_NODES, 16, number of output neurons / MAC lanes (>=1)
ACC_WIDTH, 24, signed accumulator width; must be >= 2*DATA_WIDTH+clog2(INPUT_NODES)
FRAC_BITS, 0, fractional bits of activations and weights; result is shifted right by this amount
RELU_EN, 1, 1 = clamp negative results to 0; 0 = linear output
ADDR_WIDTH, clog2(INPUT_NODES), width of weight_addr

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-low
start  in  1  one-cycle request; sampled only in IDLE
input_fc  in  DATA_WIDTH*INPUT_NODES  activations; element j at [DATA_WIDTH*j +: DATA_WIDTH]; latched on accepted start
bias  in  DATA_WIDTH*OUTPUT_NODES  per-lane bias; must be stable while busy
weight_rd  out  1  weight memory read enable
weight_addr  out  ADDR_WIDTH  input index j being fetched
weight_data  in  DATA_WIDTH*OUTPUT_NODES  weight row for j; lane i at [DATA_WIDTH*i +: DATA_WIDTH]; valid 1 cycle after weight_rd
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse; output_fc valid
output_fc  out  DATA_WIDTH*OUTPUT_NODES  results; held until the next done

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy, done and weight_rd = 0; weight_addr = 0; output_fc = 0; accumulators and counters cleared. Reset mid-operation aborts the computation; no done is produced.
- FSM states:
  - IDLE -> FETCH on start=1: latch input_fc and clear accumulators.
  - FETCH: weight_rd=1, weight_addr = 0..INPUT_NODES-1, one per cycle. After the last address -> DRAIN.
  - DRAIN: one cycle, consumes the final weight row.
  - FINISH: one cycle, computes and registers output_fc.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Timing: start accepted at cycle T; addresses issued in T+1..T+INPUT_NODES; weight row k arrives at T+2+k and is accumulated with activation k at the end of that cycle; output_fc is registered at the end of T+INPUT_NODES+2; done is high in T+INPUT_NODES+3. Total latency = INPUT_NODES+3 cycles. Back-to-back: the earliest next start is accepted in the cycle after done.
- start while busy, including the DONE cycle: ignored, no effect.
- MAC: product = signed(act) * signed(w), 2*DATA_WIDTH bits, sign-extended to ACC_WIDTH and added. Two's-complement wrap is permitted only if the ACC_WIDTH constraint is violated (configuration error, assert in sim).
- Finish per lane:
  - s = acc + (sign-extended bias << FRAC_BITS)
  - arithmetic shift right by FRAC_BITS (truncation toward -inf)
  - if RELU_EN and s<0 then s=0
  - saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]
- output_fc changes only in FINISH; it is stable in all other states.
- INPUT_NODES=1: FETCH lasts one cycle; timing formula still holds.

Decomposition:
- Package fc_pkg: state enum (IDLE, FETCH, DRAIN, FINISH, DONE), clog2 helper, saturate/ReLU function parameterised on ACC_WIDTH and DATA_WIDTH.
- Sub-module fc_mac_lane (one per output node, generate loop): accumulator, clear, enable, and the finish pipeline stage. The top level holds the FSM, index counter, input latch and activation mux.

Test Plan:
- INPUT_NODES=4, OUTPUT_NODES=2, FRAC_BITS=0, RELU_EN=1; inputs [1,2,3,4]; lane0 weights all 1, lane1 all -1; bias 0 -> output_fc = {0, 10}; done exactly 7 cycles after start; weight_addr sequence 0,1,2,3.
- Same configuration, inputs all 127, lane0 weights all 127; RELU_EN=0 with lane1 weights all -128 -> lane0=127 (saturated), lane1=-128 (saturated).
- FRAC_BITS=4: inputs all 16 (1.0), weights all 8 (0.5), bias 1 -> (512+16)>>4 = 33.
- start pulsed again at cycles T+2 and T+7 (the DONE cycle) -> both ignored; a single done; output matches the first run.
- reset asserted at T+3 -> busy, done, weight_rd and output_fc = 0 immediately; a fresh start afterwards produces the correct result with the standard latency.
- input_fc changed at T+1 -> result uses the values latched at T.
